// File: rtl/csel_pkg.sv
// Shared helpers for the pipelined carry-select adder: block-count helper and
// an elaboration-time divisibility check.
`ifndef CSEL_PKG_SV
`define CSEL_PKG_SV

// Aborts elaboration unless W splits evenly into at least one B-bit block.
`define CSEL_CHECK_DIV(W, B) \
  if (((B) == 0) || ((W) < (B)) || (((W) % (B)) != 0)) begin : g_div_check \
    $error("pipelined_csel_adder: WIDTH must be a non-zero multiple of BLOCK"); \
  end

package csel_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_BLOCK = 4;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  // Number of carry-select blocks, which is also the pipeline depth.
  function automatic int unsigned nblk(input int unsigned w, input int unsigned b);
    return (b == 0) ? 1 : w / b;
  endfunction

endpackage

`endif

// File: rtl/pipelined_csel_adder_if.sv
// Valid/ready operand and result streams of the pipelined carry-select adder.
interface pipelined_csel_adder_if #(
  parameter int unsigned WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, x, y, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, x, y, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/csel_block.sv
// One carry-select block: both carry-in cases are summed up front and the
// late-arriving carry only drives the final mux.
module csel_block #(
  parameter int unsigned BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             c_in,
  output logic [BLOCK-1:0] s,
  output logic             c_out
);

  localparam int unsigned BW = BLOCK + 1;

  logic [BW-1:0] s0;
  logic [BW-1:0] s1;

  assign s0 = BW'(a) + BW'(b);
  assign s1 = BW'(a) + BW'(b) + BW'(1);

  assign {c_out, s} = c_in ? s1 : s0;

endmodule

// File: rtl/pipelined_csel_adder.sv
// Pipelined carry-select adder/subtractor: one BLOCK-bit slice resolved per
// stage, whole pipeline advancing together under a single valid/ready enable.
module pipelined_csel_adder
  import csel_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned BLOCK = DEF_BLOCK
) (
  input logic                    clk,
  input logic                    rst_n,
  pipelined_csel_adder_if.slave  bus
);

  localparam int unsigned NBLK = nblk(WIDTH, BLOCK);
  localparam int unsigned MSB  = WIDTH - 1;

  `CSEL_CHECK_DIV(WIDTH, BLOCK)

  logic             adv;
  logic [WIDTH-1:0] y_eff;
  logic             c0;

  // Token state; index k is the token waiting in front of block k, index NBLK is the output.
  logic [NBLK:0]    v_q;
  logic [NBLK:0]    c_q;
  logic [NBLK-1:0]  xm_q;
  logic [NBLK-1:0]  ym_q;
  logic             ovf_q;
  logic [WIDTH-1:0] x_q  [NBLK];
  logic [WIDTH-1:0] y_q  [NBLK];
  logic [WIDTH-1:0] ps_q [NBLK+1];

  logic [BLOCK-1:0] s_c  [NBLK];
  logic             co_c [NBLK];

  assign adv   = ~v_q[NBLK] | bus.out_ready;
  assign y_eff = bus.sub ? ~bus.y : bus.y;
  assign c0    = bus.sub | bus.cin;

  for (genvar k = 0; k < NBLK; k++) begin : g_stage
    csel_block #(.BLOCK(BLOCK)) u_blk (
      .a     (x_q[k][BLOCK-1:0]),
      .b     (y_q[k][BLOCK-1:0]),
      .c_in  (c_q[k]),
      .s     (s_c[k]),
      .c_out (co_c[k])
    );
  end

  // Operands shift right so each stage always works on its low block; finished
  // sum blocks enter the partial sum from the top and settle into place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      xm_q  <= '0;
      ym_q  <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < NBLK; k++) begin
        x_q[k] <= '0;
        y_q[k] <= '0;
      end
      for (int k = 0; k <= NBLK; k++) begin
        ps_q[k] <= '0;
      end
    end else if (adv) begin
      v_q[0]  <= bus.in_valid;
      c_q[0]  <= c0;
      x_q[0]  <= bus.x;
      y_q[0]  <= y_eff;
      xm_q[0] <= bus.x[MSB];
      ym_q[0] <= y_eff[MSB];
      ps_q[0] <= '0;
      for (int k = 0; k < NBLK; k++) begin
        v_q[k+1]  <= v_q[k];
        c_q[k+1]  <= co_c[k];
        ps_q[k+1] <= WIDTH'({s_c[k], ps_q[k]} >> BLOCK);
      end
      for (int k = 1; k < NBLK; k++) begin
        x_q[k]  <= x_q[k-1] >> BLOCK;
        y_q[k]  <= y_q[k-1] >> BLOCK;
        xm_q[k] <= xm_q[k-1];
        ym_q[k] <= ym_q[k-1];
      end
      ovf_q <= (xm_q[NBLK-1] == ym_q[NBLK-1]) &
               (s_c[NBLK-1][BLOCK-1] != xm_q[NBLK-1]);
    end
  end

  assign bus.in_ready  = adv;
  assign bus.out_valid = v_q[NBLK];
  assign bus.sum       = ps_q[NBLK];
  assign bus.cout      = c_q[NBLK];
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_csel_adder.sv
// Directed and randomised checks of pipelined_csel_adder at WIDTH=16, BLOCK=4.
module tb_pipelined_csel_adder;

  logic clk = 1'b0;
  logic rst_n;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipelined_csel_adder_if #(.WIDTH(16)) bus ();

  pipelined_csel_adder #(.WIDTH(16), .BLOCK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: integer arithmetic, signed range test for overflow.
  function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic s);
    int          sa, sb, sr;
    logic [16:0] r;
    logic        o;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (s) begin
      r  = {1'b0, a - b};
      r[16] = (a >= b);
      sr = sa - sb;
    end else begin
      r  = 17'(a) + 17'(b) + 17'(ci);
      sr = sa + sb + int'(ci);
    end
    o = (sr > 32767) || (sr < -32768);
    return {o, r};
  endfunction

  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input logic s,
                        input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    bus.x = a; bus.y = b; bus.cin = ci; bus.sub = s;
    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check({tag, "_lat"},  32'(lat), 32'd4);
    check({tag, "_sum"},  32'(bus.sum), 32'(es));
    check({tag, "_cout"}, 32'(bus.cout), 32'(ec));
    check({tag, "_ovf"},  32'(bus.ovf), 32'(eo));
    tick();
  endtask

  initial begin
    int          sent, recv, stalls, seen;
    logic [3:0]  pat;
    logic [9:0]  ov_vec;
    logic [17:0] q[$];
    logic [17:0] exp_r;

    rst_n = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.x = '0; bus.y = '0; bus.cin = 1'b0; bus.sub = 1'b0;
    #2 rst_n = 1'b0;
    #10;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_sum",       32'(bus.sum), 32'd0);
    check("rst_cout",      32'(bus.cout), 32'd0);
    check("rst_ovf",       32'(bus.ovf), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Directed arithmetic
    run_op("add6_3",     16'h0006, 16'h0003, 1'b0, 1'b0, 16'h0009, 1'b0, 1'b0);
    run_op("ripple",     16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("pos_ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub3_5",     16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_eq",     16'h0005, 16'h0005, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_op("sub_cin_ig", 16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000F, 1'b1, 1'b0);
    run_op("neg_ovf",    16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    run_op("add_cin",    16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

    // Backpressure: six back-to-back adds with a three-cycle output stall
    sent = 0; recv = 0; stalls = 0;
    for (int t = 0; t < 60 && recv < 6; t++) begin
      bus.in_valid  = (sent < 6);
      bus.x         = 16'(sent + 1);
      bus.y         = 16'(sent + 1);
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      bus.out_ready = !(t >= 6 && t <= 8);
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        stalls++;
        check("bp_stall_in_ready", 32'(bus.in_ready), 32'd0);
      end
      if (bus.out_valid && bus.out_ready) begin
        check("bp_sum", 32'(bus.sum), 32'(2 * (recv + 1)));
        recv++;
      end
      if (bus.in_valid && bus.in_ready) sent++;
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("bp_count",  32'(recv), 32'd6);
    check("bp_stalls", 32'(stalls), 32'd3);
    check("bp_no_dup", 32'(bus.out_valid), 32'd0);

    // Bubbles: in_valid 1,0,0,1 reappears on out_valid five samples later
    pat = 4'b1001;
    ov_vec = '0;
    for (int t = 0; t < 10; t++) begin
      bus.in_valid  = (t < 4) ? pat[t] : 1'b0;
      bus.x         = 16'h0100 + 16'(t);
      bus.y         = 16'h0011;
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      ov_vec[t] = bus.out_valid;
      if (t == 5) check("bubble_sum0", 32'(bus.sum), 32'h0111);
      if (t == 8) check("bubble_sum3", 32'(bus.sum), 32'h0114);
      tick();
    end
    check("bubble_pattern", 32'(ov_vec), 32'(10'b01_0010_0000));

    // Reset with three tokens in flight, head token stalled at the output
    bus.out_ready = 1'b0;
    for (int t = 0; t < 5; t++) begin
      bus.in_valid = (t < 3);
      bus.x   = (t == 0) ? 16'h8000 : 16'(t);
      bus.y   = (t == 0) ? 16'hFFFF : 16'(t);
      bus.cin = 1'b0;
      bus.sub = 1'b0;
      tick();
    end
    bus.in_valid = 1'b0;
    check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
    check("pre_rst_out",   32'({bus.ovf, bus.cout, bus.sum}), 32'h3_7FFF);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_sum",   32'(bus.sum), 32'd0);
    check("mid_rst_flags", 32'({bus.ovf, bus.cout}), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (bus.out_valid) seen++;
    end
    check("post_rst_stale", 32'(seen), 32'd0);
    run_op("post_rst", 16'h00F0, 16'h0F0F, 1'b0, 1'b0, 16'h0FFF, 1'b0, 1'b0);

    // Randomised traffic against the reference model
    for (int t = 0; t < 300; t++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.x         = 16'($urandom);
      bus.y         = 16'($urandom);
      bus.cin       = 1'($urandom);
      bus.sub       = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          check("rnd_extra", 32'(bus.out_valid), 32'd0);
        end else begin
          exp_r = q.pop_front();
          check("rnd_result", 32'({bus.ovf, bus.cout, bus.sum}), 32'(exp_r));
        end
      end
      if (bus.in_valid && bus.in_ready)
        q.push_back(model(bus.x, bus.y, bus.cin, bus.sub));
      tick();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (bus.out_valid) begin
        if (q.size() == 0) begin
          check("rnd_drain_extra", 32'(bus.out_valid), 32'd0);
        end else begin
          exp_r = q.pop_front();
          check("rnd_drain", 32'({bus.ovf, bus.cout, bus.sum}), 32'(exp_r));
        end
      end
      tick();
    end
    check("rnd_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
